// File: rtl/io_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_port_arbiter
// Description : Round-robin arbiter sharing the io_driver port bus between
//               master 0 (CPU load/store path) and master 1 (debug/monitor).
//               One transaction at a time: IDLE -> ACCESS (ACCESS_CYCLES
//               cycles of strobe/addr/data on the bus) -> ACK (one-cycle ack
//               to the winner) -> IDLE.
// Ports       :
//   clk, rst                 clock, asynchronous active-high reset
//   m{0,1}_req               request, held until the matching ack
//   m{0,1}_we                1 = write, 0 = read
//   m{0,1}_addr / _wdata     transaction address / write data
//   m{0,1}_ack               one-cycle completion pulse
//   m{0,1}_rdata             last read result of that master
//   port_read / port_write   registered strobes to io_driver
//   port_addr / port_write_data  registered bus address / write data
//   port_read_data           read data from io_driver (sampled on last
//                            ACCESS cycle)
//   busy                     high during ACCESS and ACK
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              port_read,
  output logic              port_write,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_write_data,
  input  logic [DATA_W-1:0] port_read_data,
  output logic              busy
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              port_read_q, port_read_d;
  logic              port_write_q, port_write_d;
  logic [ADDR_W-1:0] port_addr_q, port_addr_d;
  logic [DATA_W-1:0] port_wdata_q, port_wdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              busy_q, busy_d;
  logic              grant_m1;

  // On a tie the master that did not win last time is served.
  assign grant_m1 = m1_req & (~m0_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          winner_d     = grant_m1;
          last_grant_d = grant_m1;
          we_d         = grant_m1 ? m1_we    : m0_we;
          addr_d       = grant_m1 ? m1_addr  : m0_addr;
          wdata_d      = grant_m1 ? m1_wdata : m0_wdata;
          cnt_d        = C_CNT_LOAD;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          // Last bus cycle: io_driver's read data is valid now.
          if (!we_q) begin
            if (winner_q) m1_rdata_d = port_read_data;
            else          m0_rdata_d = port_read_data;
          end
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus and handshake outputs are registered, so they are derived from the
    // state being entered and the transaction copy that will be held there.
    port_read_d  = (state_d == S_ACCESS) && !we_d;
    port_write_d = (state_d == S_ACCESS) && we_d;
    port_addr_d  = (state_d == S_ACCESS) ? addr_d : '0;
    port_wdata_d = ((state_d == S_ACCESS) && we_d) ? wdata_d : '0;
    m0_ack_d     = (state_d == S_ACK) && !winner_d;
    m1_ack_d     = (state_d == S_ACK) && winner_d;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      port_read_q  <= 1'b0;
      port_write_q <= 1'b0;
      port_addr_q  <= '0;
      port_wdata_q <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      port_read_q  <= port_read_d;
      port_write_q <= port_write_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack          = m0_ack_q;
  assign m1_ack          = m1_ack_q;
  assign m0_rdata        = m0_rdata_q;
  assign m1_rdata        = m1_rdata_q;
  assign port_read       = port_read_q;
  assign port_write      = port_write_q;
  assign port_addr       = port_addr_q;
  assign port_write_data = port_wdata_q;
  assign busy            = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_arbiter
// Description : Bench for io_port_arbiter. Two instances (ACCESS_CYCLES = 1
//               and 3) each with their own requesters; a transaction-position
//               model predicts every output each cycle, plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index [d] selects instance (0: ACCESS_CYCLES=1, 1: ACCESS_CYCLES=3),
  // [m] selects master.
  logic        req    [2][2];
  logic        we_i   [2][2];
  logic [15:0] addr_i [2][2];
  logic [15:0] wd_i   [2][2];
  logic [15:0] rd_bus [2];
  logic        ack    [2][2];
  logic [15:0] rdata  [2][2];
  logic        prd [2];
  logic        pwr [2];
  logic        busy[2];
  logic [15:0] paddr[2];
  logic [15:0] pwd  [2];

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  io_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(req[0][0]), .m0_we(we_i[0][0]), .m0_addr(addr_i[0][0]), .m0_wdata(wd_i[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we_i[0][1]), .m1_addr(addr_i[0][1]), .m1_wdata(wd_i[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .port_read(prd[0]), .port_write(pwr[0]), .port_addr(paddr[0]),
    .port_write_data(pwd[0]), .port_read_data(rd_bus[0]), .busy(busy[0])
  );

  io_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(req[1][0]), .m0_we(we_i[1][0]), .m0_addr(addr_i[1][0]), .m0_wdata(wd_i[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we_i[1][1]), .m1_addr(addr_i[1][1]), .m1_wdata(wd_i[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .port_read(prd[1]), .port_write(pwr[1]), .port_addr(paddr[1]),
    .port_write_data(pwd[1]), .port_read_data(rd_bus[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos = position inside a transaction: 0 idle, 1..AC bus cycles, AC+1 ack.
  int          pos   [2] = '{0, 0};
  logic        mlast [2] = '{1'b1, 1'b1};
  logic        mwin  [2] = '{1'b0, 1'b0};
  logic        mwe   [2] = '{1'b0, 1'b0};
  logic [15:0] maddr [2] = '{16'h0, 16'h0};
  logic [15:0] mwd   [2] = '{16'h0, 16'h0};
  logic [15:0] mrd   [2][2] = '{'{16'h0, 16'h0}, '{16'h0, 16'h0}};

  function automatic int acf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        pos[d]    <= 0;
        mlast[d]  <= 1'b1;
        mwin[d]   <= 1'b0;
        mwe[d]    <= 1'b0;
        maddr[d]  <= 16'h0;
        mwd[d]    <= 16'h0;
        mrd[d][0] <= 16'h0;
        mrd[d][1] <= 16'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pos[d] == 0) begin
          if (req[d][0] || req[d][1]) begin
            mwin[d]  <= pick(req[d][0], req[d][1], mlast[d]);
            mlast[d] <= pick(req[d][0], req[d][1], mlast[d]);
            mwe[d]   <= we_i[d][pick(req[d][0], req[d][1], mlast[d])];
            maddr[d] <= addr_i[d][pick(req[d][0], req[d][1], mlast[d])];
            mwd[d]   <= wd_i[d][pick(req[d][0], req[d][1], mlast[d])];
            pos[d]   <= 1;
          end
        end else if (pos[d] <= acf(d)) begin
          if (pos[d] == acf(d) && !mwe[d]) mrd[d][mwin[d]] <= rd_bus[d];
          pos[d] <= pos[d] + 1;
        end else begin
          pos[d] <= 0;
        end
      end
    end
  end

  function automatic logic on_bus(input int d);
    return (pos[d] >= 1) && (pos[d] <= acf(d));
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("port_read",  d, 32'(prd[d]),  32'(on_bus(d) && !mwe[d]));
        chk("port_write", d, 32'(pwr[d]),  32'(on_bus(d) && mwe[d]));
        chk("port_addr",  d, 32'(paddr[d]), on_bus(d) ? 32'(maddr[d]) : 32'h0);
        chk("port_wdata", d, 32'(pwd[d]),  (on_bus(d) && mwe[d]) ? 32'(mwd[d]) : 32'h0);
        chk("m0_ack",     d, 32'(ack[d][0]), 32'((pos[d] == acf(d) + 1) && !mwin[d]));
        chk("m1_ack",     d, 32'(ack[d][1]), 32'((pos[d] == acf(d) + 1) && mwin[d]));
        chk("m0_rdata",   d, 32'(rdata[d][0]), 32'(mrd[d][0]));
        chk("m1_rdata",   d, 32'(rdata[d][1]), 32'(mrd[d][1]));
        chk("busy",       d, 32'(busy[d]), 32'(pos[d] != 0));
      end
    end
  end

  // ---------------- stimulus ----------------
  int order[4];
  int n, cnt, ackat, acks;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_bus[d] = 16'h0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; we_i[d][m] = 1'b0; addr_i[d][m] = 16'h0; wd_i[d][m] = 16'h0;
      end
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",  d, 32'(busy[d]), 0);
      chk("rst_strobe", d, 32'({prd[d], pwr[d]}), 0);
      chk("rst_ack",   d, 32'({ack[d][0], ack[d][1]}), 0);
      chk("rst_rdata", d, 32'(rdata[d][0] | rdata[d][1]), 0);
    end
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // Write on the single-cycle instance.
    @(negedge clk);
    req[0][0] = 1'b1; we_i[0][0] = 1'b1; addr_i[0][0] = 16'h0010; wd_i[0][0] = 16'h0003;
    @(negedge clk);
    chk("t2_write", 0, 32'(pwr[0]), 1);
    chk("t2_addr",  0, 32'(paddr[0]), 32'h0010);
    chk("t2_data",  0, 32'(pwd[0]), 32'h0003);
    chk("t2_noread", 0, 32'(prd[0]), 0);
    @(negedge clk);
    chk("t2_ack",    0, 32'(ack[0][0]), 1);
    chk("t2_strobe_off", 0, 32'({prd[0], pwr[0]}), 0);
    req[0][0] = 1'b0;
    @(negedge clk);
    chk("t2_idle", 0, 32'(busy[0]), 0);

    // Read by master 1.
    req[0][1] = 1'b1; we_i[0][1] = 1'b0; addr_i[0][1] = 16'h0020; rd_bus[0] = 16'hA5A5;
    @(negedge clk);
    chk("t3_read", 0, 32'(prd[0]), 1);
    chk("t3_addr", 0, 32'(paddr[0]), 32'h0020);
    @(negedge clk);
    chk("t3_ack",   0, 32'(ack[0][1]), 1);
    chk("t3_rdata", 0, 32'(rdata[0][1]), 32'hA5A5);
    chk("t3_m0_rdata", 0, 32'(rdata[0][0]), 0);
    req[0][1] = 1'b0;
    @(negedge clk);

    // Both masters held: grants must alternate starting with m0.
    req[0][0] = 1'b1; we_i[0][0] = 1'b1; addr_i[0][0] = 16'h0100; wd_i[0][0] = 16'h1111;
    req[0][1] = 1'b1; we_i[0][1] = 1'b1; addr_i[0][1] = 16'h0200; wd_i[0][1] = 16'h2222;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (ack[0][0])      begin order[n] = 0; n++; end
      else if (ack[0][1]) begin order[n] = 1; n++; end
      if (n == 4) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    chk("t4_count", 0, 32'(n), 4);
    for (int k = 0; k < n; k++) chk("t4_order", 0, 32'(order[k]), 32'(k % 2));
    @(negedge clk);

    // Three-cycle read on the second instance.
    req[1][0] = 1'b1; we_i[1][0] = 1'b0; addr_i[1][0] = 16'h0040; rd_bus[1] = 16'h1234;
    cnt = 0; ackat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (prd[1]) begin cnt++; chk("t5_addr", 1, 32'(paddr[1]), 32'h0040); end
      if (ack[1][0]) begin ackat = i; req[1][0] = 1'b0; end
    end
    chk("t5_read_cycles", 1, 32'(cnt), 3);
    chk("t5_ack_cycle",   1, 32'(ackat), 3);
    chk("t5_rdata",       1, 32'(rdata[1][0]), 32'h1234);

    // Request withdrawn during ACCESS still completes once.
    req[1][1] = 1'b1; we_i[1][1] = 1'b1; addr_i[1][1] = 16'h0055; wd_i[1][1] = 16'h0066;
    @(negedge clk);
    chk("t6_write", 1, 32'(pwr[1]), 1);
    req[1][1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[1][1]) acks++;
    end
    chk("t6_acks", 1, 32'(acks), 1);
    chk("t6_idle", 1, 32'(busy[1]), 0);

    // Asynchronous reset in the middle of ACCESS.
    req[1][0] = 1'b1; we_i[1][0] = 1'b1; addr_i[1][0] = 16'h0077; wd_i[1][0] = 16'h0088;
    @(negedge clk);
    chk("t1_pre_write", 1, 32'(pwr[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_strobes", 1, 32'({prd[1], pwr[1]}), 0);
    chk("t1_busy",    1, 32'(busy[1]), 0);
    chk("t1_acks",    1, 32'({ack[1][0], ack[1][1]}), 0);
    chk("t1_rdata",   0, 32'(rdata[0][1]), 0);
    req[1][0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_after_busy", 1, 32'(busy[1]), 0);
    chk("t1_after_ack",  1, 32'(ack[1][0]), 0);

    // Randomized traffic on both instances.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rd_bus[d] = 16'($urandom);
        for (int m = 0; m < 2; m++) begin
          if (req[d][m] && ack[d][m]) begin
            req[d][m] = 1'b0;
          end else if (req[d][m] && $urandom_range(0, 39) == 0) begin
            req[d][m] = 1'b0;
          end else if (!req[d][m] && $urandom_range(0, 2) == 0) begin
            req[d][m]    = 1'b1;
            we_i[d][m]   = 1'($urandom_range(0, 1));
            addr_i[d][m] = 16'($urandom);
            wd_i[d][m]   = 16'($urandom);
          end else if (req[d][m] && $urandom_range(0, 3) == 0) begin
            we_i[d][m]   = 1'($urandom_range(0, 1));
            addr_i[d][m] = 16'($urandom);
            wd_i[d][m]   = 16'($urandom);
          end
        end
      end
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
